// File: rtl/wb_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : wb_arb_pkg
// Brief    : Shared arbiter state encoding and grant helper.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  function automatic logic [1:0] grant_onehot(input arb_state_e st);
    case (st)
      OWN0:    return 2'b01;
      OWN1:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_if.sv
//------------------------------------------------------------------------------
// Module   : wb_if
// Brief    : Classic Wishbone bus bundle with master/slave views.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface wb_if #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32
);
  logic [WB_ADDR_WIDTH-1:0]   adr;
  logic [WB_DATA_WIDTH-1:0]   dat_w;
  logic [WB_DATA_WIDTH-1:0]   dat_r;
  logic [WB_DATA_WIDTH/8-1:0] sel;
  logic                       we;
  logic                       cyc;
  logic                       stb;
  logic                       ack;
  logic                       err;

  modport master (output adr, dat_w, sel, we, cyc, stb, input dat_r, ack, err);
  modport slave  (input adr, dat_w, sel, we, cyc, stb, output dat_r, ack, err);
endinterface

`default_nettype wire

// File: rtl/wb_arb_watchdog.sv
//------------------------------------------------------------------------------
// Module   : wb_arb_watchdog
// Brief    : Counts unanswered strobed cycles and pulses o_timeout at the limit.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire logic clk,
  input  wire logic rstn,
  input  wire logic i_req,
  input  wire logic i_ack,
  input  wire logic i_err,
  input  wire logic i_clr,
  output logic      o_timeout
);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      localparam int c_wd_w = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [c_wd_w-1:0] c_limit = c_wd_w'(TIMEOUT_CYCLES);

      logic [c_wd_w-1:0] r_wd;
      logic              w_hit;

      assign w_hit = i_req && (r_wd == c_limit);

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_wd <= '0;
        end else if (w_hit || i_clr || !i_req || i_ack || i_err) begin
          r_wd <= '0;
        end else begin
          r_wd <= r_wd + 1'b1;
        end
      end

      assign o_timeout = w_hit;
    end else begin : g_no_wd
      logic w_unused;
      assign w_unused  = ^{clk, rstn, i_req, i_ack, i_err, i_clr};
      assign o_timeout = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/wb_arbiter_2x1.sv
//------------------------------------------------------------------------------
// Module   : wb_arbiter_2x1
// Brief    : Round-robin two-master Wishbone arbiter with access watchdog.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_arbiter_2x1
  import wb_arb_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire logic  clk,
  input  wire logic  rstn,
  wb_if.slave        m0,
  wb_if.slave        m1,
  wb_if.master       s,
  output logic [1:0] grant,
  output logic       timeout
);

  arb_state_e r_state;
  arb_state_e w_next;
  logic       r_last;
  logic       w_own_cyc;
  logic       w_own_stb;
  logic       w_req;
  logic       w_timeout;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next == OWN0) begin
        r_last <= 1'b0;
      end else if (w_next == OWN1) begin
        r_last <= 1'b1;
      end
    end
  end

  // Owner releases by dropping cyc; a waiting peer takes over with no idle cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m0.cyc && m1.cyc) begin
          w_next = r_last ? OWN0 : OWN1;
        end else if (m0.cyc) begin
          w_next = OWN0;
        end else if (m1.cyc) begin
          w_next = OWN1;
        end
      end
      OWN0:    if (!m0.cyc) w_next = m1.cyc ? OWN1 : IDLE;
      OWN1:    if (!m1.cyc) w_next = m0.cyc ? OWN0 : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_own_cyc = 1'b0;
    w_own_stb = 1'b0;
    case (r_state)
      OWN0: begin
        w_own_cyc = m0.cyc;
        w_own_stb = m0.stb;
      end
      OWN1: begin
        w_own_cyc = m1.cyc;
        w_own_stb = m1.stb;
      end
      default: ;
    endcase
  end

  assign w_req = w_own_cyc && w_own_stb;

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rstn      (rstn),
    .i_req     (w_req),
    .i_ack     (s.ack),
    .i_err     (s.err),
    .i_clr     (w_next != r_state),
    .o_timeout (w_timeout)
  );

  // Slave-side request mux; a timeout masks cyc/stb so the slave drops the access.
  always_comb begin
    s.adr   = {WB_ADDR_WIDTH{1'b0}};
    s.dat_w = {WB_DATA_WIDTH{1'b0}};
    s.sel   = {(WB_DATA_WIDTH/8){1'b0}};
    s.we    = 1'b0;
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    case (r_state)
      OWN0: begin
        s.adr   = m0.adr;
        s.dat_w = m0.dat_w;
        s.sel   = m0.sel;
        s.we    = m0.we;
        s.cyc   = m0.cyc && !w_timeout;
        s.stb   = m0.stb && !w_timeout;
      end
      OWN1: begin
        s.adr   = m1.adr;
        s.dat_w = m1.dat_w;
        s.sel   = m1.sel;
        s.we    = m1.we;
        s.cyc   = m1.cyc && !w_timeout;
        s.stb   = m1.stb && !w_timeout;
      end
      default: ;
    endcase
  end

  always_comb begin
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    m0.dat_r = s.dat_r;
    m1.dat_r = s.dat_r;
    case (r_state)
      OWN0: begin
        m0.ack = s.ack && !w_timeout;
        m0.err = s.err || w_timeout;
      end
      OWN1: begin
        m1.ack = s.ack && !w_timeout;
        m1.err = s.err || w_timeout;
      end
      default: ;
    endcase
  end

  assign grant   = grant_onehot(r_state);
  assign timeout = w_timeout;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter_2x1.sv
//------------------------------------------------------------------------------
// Module   : tb_wb_arbiter_2x1
// Brief    : Scoreboard bench for wb_arbiter_2x1 with a latency-encoding slave.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_arbiter_2x1;

  localparam int T = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  wb_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32)) m0_if ();
  wb_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32)) m1_if ();
  wb_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32)) s_if ();

  logic [1:0] grant;
  logic       timeout;

  wb_arbiter_2x1 #(
    .WB_ADDR_WIDTH  (32),
    .WB_DATA_WIDTH  (32),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if),
    .grant   (grant),
    .timeout (timeout)
  );

  // Master drive/observe arrays, indexed by master id.
  logic        mcyc [2];
  logic        mstb [2];
  logic        mwe  [2];
  logic [31:0] madr [2];
  logic [31:0] mdat [2];
  logic [3:0]  msel [2];
  logic        mack [2];
  logic        merr [2];
  logic [31:0] mdr  [2];

  assign m0_if.cyc = mcyc[0];  assign m1_if.cyc = mcyc[1];
  assign m0_if.stb = mstb[0];  assign m1_if.stb = mstb[1];
  assign m0_if.we  = mwe[0];   assign m1_if.we  = mwe[1];
  assign m0_if.adr = madr[0];  assign m1_if.adr = madr[1];
  assign m0_if.dat_w = mdat[0]; assign m1_if.dat_w = mdat[1];
  assign m0_if.sel = msel[0];  assign m1_if.sel = msel[1];
  assign mack[0] = m0_if.ack;  assign mack[1] = m1_if.ack;
  assign merr[0] = m0_if.err;  assign merr[1] = m1_if.err;
  assign mdr[0]  = m0_if.dat_r; assign mdr[1] = m1_if.dat_r;

  function automatic logic [31:0] resp(input logic [31:0] a);
    return a ^ 32'hCEADBCEB;
  endfunction

  // Slave: adr[11:8] = wait states (15 = never), adr[12] = issuing master, adr[7:4] = sel.
  // Its ack comes from registered progress, so it can land in a masked timeout cycle.
  logic       r_act;
  logic [3:0] r_cnt;
  logic       s_req;
  logic [3:0] s_waits;
  assign s_req      = s_if.cyc && s_if.stb;
  assign s_waits    = s_if.adr[11:8];
  assign s_if.ack   = (s_req || r_act) && (s_waits != 4'hF) && (r_cnt == s_waits);
  assign s_if.err   = 1'b0;
  assign s_if.dat_r = resp(s_if.adr);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_act <= 1'b0;
      r_cnt <= 4'd0;
    end else if (s_if.ack || !s_req) begin
      r_act <= 1'b0;
      r_cnt <= 4'd0;
    end else begin
      r_act <= 1'b1;
      r_cnt <= r_cnt + 4'd1;
    end
  end

  typedef struct {
    logic        is_err;
    logic        we;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic gseq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_exp_to = 0;
  int   n_to     = 0;
  logic ref_last = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int q_size(input int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t q_pop(input int id);
    return (id == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  function automatic int pick_waits();
    int r;
    r = int'($urandom_range(0, 11));
    if (r == 10) return 15;
    if (r == 11) return T;
    return r;
  endfunction

  // One classic cycle of n beats; w<0 / we_mode<0 select random values.
  task automatic do_burst(input int id, input int n, input int w, input int we_mode);
    int          wt;
    int          k;
    logic [31:0] r;
    logic [3:0]  sl;
    exp_t        e;
    @(posedge clk); #1;
    mcyc[id] = 1'b1;
    for (int b = 0; b < n; b++) begin
      wt = (w >= 0) ? w : pick_waits();
      r  = $urandom();
      sl = 4'($urandom_range(1, 15));
      madr[id] = {r[31:13], id[0], 4'(wt), sl, r[3:0]};
      mwe[id]  = (we_mode >= 0) ? we_mode[0] : r[5];
      mdat[id] = resp(madr[id]);
      msel[id] = sl;
      mstb[id] = 1'b1;
      e.is_err = (wt + 1 > T);
      e.we     = mwe[id];
      e.data   = resp(madr[id]);
      e.lat    = e.is_err ? T + 1 : wt + 1;
      if (e.is_err) n_exp_to++;
      if (id == 0) q0.push_back(e); else q1.push_back(e);
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!(mack[id] || merr[id]) && k < 60);
      if (!(mack[id] || merr[id])) begin
        n_checks++;
        n_errors++;
        $display("FAIL resp_wait m%0d: no ack/err after %0d cycles, required one", id, k);
      end
      @(posedge clk); #1;
    end
    mcyc[id] = 1'b0;
    mstb[id] = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every master response and checks slave-side routing.
  int   bcnt [2];
  logic [1:0] prev_grant;
  logic prev_scyc;
  exp_t me;

  always @(negedge clk) begin
    if (!rstn) begin
      bcnt[0]    = 0;
      bcnt[1]    = 0;
      prev_grant = 2'b00;
      prev_scyc  = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mstb[i] && grant[i]) bcnt[i]++;
        if (mack[i] || merr[i]) begin
          if (q_size(i) == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL spurious_resp m%0d: ack=%b err=%b, required no response", i, mack[i], merr[i]);
          end else begin
            me = q_pop(i);
            chk("resp_err", 32'(merr[i]), 32'(me.is_err));
            chk("resp_ack", 32'(mack[i]), 32'(!me.is_err));
            chk("latency", bcnt[i], me.lat);
            if (!me.we && !me.is_err) chk("rdata", mdr[i], me.data);
          end
          bcnt[i] = 0;
        end
      end
      if (s_req) chk("owner_grant", 32'(grant), s_if.adr[12] ? 32'd2 : 32'd1);
      if (s_if.ack && s_req && s_if.we) begin
        chk("wdata", s_if.dat_w, resp(s_if.adr));
        chk("wsel", 32'(s_if.sel), 32'(s_if.adr[7:4]));
      end
      if (timeout) begin
        n_to++;
        chk("to_masks_slave", 32'({s_if.cyc, s_if.stb}), 32'd0);
        chk("to_err", 32'(merr[0] || merr[1]), 32'd1);
      end
      if (grant != prev_grant && grant != 2'b00 && prev_grant != 2'b00)
        chk("switch_gap", 32'(prev_scyc), 32'd0);
      if (grant != prev_grant && grant != 2'b00) gseq.push_back(grant[1]);
      prev_grant = grant;
      prev_scyc  = s_if.cyc;
    end
  end

  task automatic tie_test(input string name);
    logic winner;
    winner = !ref_last;
    gseq.delete();
    @(negedge clk);
    fork
      do_burst(0, 3, -1, 0);
      do_burst(1, 3, -1, 0);
    join
    repeat (3) @(negedge clk);
    chk({name, "_grants"}, 32'(gseq.size()), 32'd2);
    if (gseq.size() == 2) begin
      chk({name, "_first"}, 32'(gseq[0]), 32'(winner));
      chk({name, "_second"}, 32'(gseq[1]), 32'(!winner));
    end
    ref_last = !winner;
  endtask

  initial begin
    int to_before;
    for (int i = 0; i < 2; i++) begin
      mcyc[i] = 1'b0; mstb[i] = 1'b0; mwe[i] = 1'b0;
      madr[i] = '0;   mdat[i] = '0;   msel[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_scyc_stb", 32'({s_if.cyc, s_if.stb}), 32'd0);
    chk("rst_sadr", s_if.adr, 32'd0);
    chk("rst_m_resp", 32'({mack[0], merr[0], mack[1], merr[1]}), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    tie_test("tie_reset");

    // Single m0 read, two wait states; observe arbitration latency.
    gseq.delete();
    @(negedge clk);
    fork
      do_burst(0, 1, 2, 0);
      begin
        @(negedge clk);
        chk("lat_scyc", 32'(s_if.cyc), 32'd0);
        chk("lat_grant0", 32'(grant), 32'd0);
        @(negedge clk);
        chk("lat_grant1", 32'(grant), 32'd1);
      end
    join
    repeat (2) @(negedge clk);
    chk("single_idle", 32'(grant), 32'd0);
    ref_last = 1'b0;

    tie_test("tie_repeat");

    // m1 4-beat write burst, m0 requests mid-burst.
    gseq.delete();
    @(negedge clk);
    fork
      do_burst(1, 4, 2, 1);
      begin
        repeat (3) @(posedge clk);
        do_burst(0, 1, 1, 0);
      end
    join
    repeat (3) @(negedge clk);
    chk("burst_grants", 32'(gseq.size()), 32'd2);
    if (gseq.size() == 2) chk("burst_order", 32'({gseq[0], gseq[1]}), 32'b10);

    to_before = n_to;
    do_burst(0, 1, 15, 1);
    repeat (2) @(negedge clk);
    chk("noack_pulses", n_to - to_before, 1);

    to_before = n_to;
    do_burst(0, 1, T, 0);
    repeat (2) @(negedge clk);
    chk("ack_at_limit_pulses", n_to - to_before, 1);

    // Reset pulse during an m1 read wait state.
    @(posedge clk); #1;
    madr[1] = {19'h0, 1'b1, 4'd5, 4'd1, 4'd0};
    mwe[1]  = 1'b0;
    mcyc[1] = 1'b1;
    mstb[1] = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("prerst_grant", 32'(grant), 32'd2);
    rstn = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_scyc", 32'({s_if.cyc, s_if.stb}), 32'd0);
    chk("async_m1_resp", 32'({mack[1], merr[1]}), 32'd0);
    mcyc[1] = 1'b0;
    mstb[1] = 1'b0;
    @(posedge clk); #3;
    rstn = 1'b1;
    ref_last = 1'b1;

    tie_test("tie_after_rst");

    fork
      repeat (15) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_burst(0, int'($urandom_range(1, 4)), -1, -1);
      end
      repeat (15) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_burst(1, int'($urandom_range(1, 4)), -1, -1);
      end
    join

    repeat (5) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("timeout_count", n_to, n_exp_to);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_bound: simulation did not finish, required completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

endmodule

`default_nettype wire
